alu2_pipe: RTL and testbench

Parametrised, pipelined successor to the single-cycle ALU1 datapath. It accepts one ALU operation per cycle over a valid/ready request channel and returns the result, carry, zero flag and a caller-supplied tag over a valid/ready response channel after a fixed, configurable latency. Back-pressure stalls the pipeline without dropping or duplicating operations. Bus functional models and upstream issue logic wait on `out_valid` instead of counting clocks.

---
 rtl/alu2_pkg.sv | 13 +
 rtl/alu2_core.sv | 36 +++
 rtl/alu2_pipe.sv | 71 +++++++
 tb/tb_alu2_pipe.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/alu2_pkg.sv
// alu2_pkg: opcode encoding and response layout shared by the alu2 datapath.
package alu2_pkg;
   localparam int ALU2_CMD_WIDTH = 3;
   typedef enum logic [ALU2_CMD_WIDTH-1:0] {ADD, SUB, AND, OR, XOR, SHL, SHR, PASSB} Alu2Op;
   // Default-width response; modules redeclare this layout at their own WIDTH/TAG_WIDTH
   typedef struct packed {
      logic [63:0] result;
      logic        co;
      logic        zero;
      logic        err;
      logic [3:0]  tag;
   } Alu2Resp;
endpackage

// File: rtl/alu2_core.sv
// alu2_core: combinational ALU datapath producing result, carry and error.
module alu2_core import alu2_pkg::*; #(
   parameter int WIDTH = 64
) (
   input  Alu2Op             op_i,
   input  logic [WIDTH-1:0]  a_i,
   input  logic [WIDTH-1:0]  b_i,
   output logic [WIDTH-1:0]  result_o,
   output logic              co_o,
   output logic              err_o
);
   localparam int SW = $clog2(WIDTH);
   logic [SW-1:0] sh;
   logic [WIDTH:0] sum, dif, shl, shr;
   assign sh  = b_i[SW-1:0];
   assign sum = {1'b0, a_i} + {1'b0, b_i};
   assign dif = {1'b0, a_i} + {1'b0, ~b_i} + (WIDTH+1)'(1);
   // The extra bit catches the last bit shifted out; it stays 0 for a zero shift
   assign shl = {1'b0, a_i} << sh;
   assign shr = {a_i, 1'b0} >> sh;
   assign err_o = 1'b0;
   always_comb begin
      result_o = '0;
      co_o = 1'b0;
      unique case (op_i)
         ADD:   {co_o, result_o} = sum;
         SUB:   {co_o, result_o} = dif;
         AND:   result_o = a_i & b_i;
         OR:    result_o = a_i | b_i;
         XOR:   result_o = a_i ^ b_i;
         SHL:   {co_o, result_o} = shl;
         SHR:   {result_o, co_o} = shr;
         PASSB: result_o = b_i;
      endcase
   end
endmodule

// File: rtl/alu2_pipe.sv
// alu2_pipe: elastic valid/ready pipeline around alu2_core with fixed latency.
module alu2_pipe import alu2_pkg::*; #(
   parameter int WIDTH     = 64,
   parameter int STAGES    = 2,
   parameter int TAG_WIDTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [ALU2_CMD_WIDTH-1:0] in_op,
   input  logic [WIDTH-1:0]          in_a,
   input  logic [WIDTH-1:0]          in_b,
   input  logic [TAG_WIDTH-1:0]      in_tag,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [WIDTH-1:0]          out_result,
   output logic                      out_co,
   output logic                      out_zero,
   output logic                      out_err,
   output logic [TAG_WIDTH-1:0]      out_tag,
   output logic                      busy
);
   typedef struct packed {
      logic [WIDTH-1:0]     result;
      logic                 co;
      logic                 zero;
      logic                 err;
      logic [TAG_WIDTH-1:0] tag;
   } alu2_resp_t;
   logic [WIDTH-1:0] core_result;
   logic core_co, core_err;
   alu2_resp_t resp_d;
   logic [STAGES-1:0] stage_valid;
   logic [STAGES:0] rdy;
   alu2_core #(.WIDTH(WIDTH)) u_core (
      .op_i(Alu2Op'(in_op)), .a_i(in_a), .b_i(in_b),
      .result_o(core_result), .co_o(core_co), .err_o(core_err)
   );
   assign resp_d = {core_result, core_co, core_result == '0, core_err, in_tag};
   // A stage loads when it is empty or its content is moving on, so bubbles collapse
   always_comb begin
      rdy[STAGES] = out_ready;
      for (int k = STAGES-1; k >= 0; k--) rdy[k] = !stage_valid[k] || rdy[k+1];
   end
   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic v_q, v_d;
      alu2_resp_t r_q, r_d;
      if (k == 0) begin : g_in
         assign v_d = in_valid;
         assign r_d = resp_d;
      end else begin : g_mid
         assign v_d = g_stage[k-1].v_q;
         assign r_d = g_stage[k-1].r_q;
      end
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            v_q <= 1'b0;
            r_q <= '0;
         end else if (rdy[k]) begin
            v_q <= v_d;
            r_q <= r_d;
         end
      end
      assign stage_valid[k] = v_q;
   end
   assign in_ready  = rdy[0];
   assign out_valid = stage_valid[STAGES-1];
   assign busy      = |stage_valid;
   assign {out_result, out_co, out_zero, out_err, out_tag} = g_stage[STAGES-1].r_q;
endmodule

// File: tb/tb_alu2_pipe.sv
// tb_alu2_pipe: scoreboard bench for alu2_pipe at WIDTH=8, STAGES=2.
module tb_alu2_pipe;
   logic clk, rst, in_valid, in_ready, out_valid, out_ready;
   logic out_co, out_zero, out_err, busy;
   logic [2:0] in_op;
   logic [7:0] in_a, in_b, out_result;
   logic [3:0] in_tag, out_tag;
   logic [14:0] bundle, held, hold;
   logic stalled;
   logic [8:0] m;
   logic [14:0] exp_q[$];
   int checks = 0, errors = 0, acc = 0, pops = 0;
   int w, n, acc0, pops0, stale, gaps, stalls;

   alu2_pipe #(.WIDTH(8), .STAGES(2), .TAG_WIDTH(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_co(out_co), .out_zero(out_zero), .out_err(out_err),
      .out_tag(out_tag), .busy(busy)
   );

   assign bundle = {out_result, out_co, out_zero, out_err, out_tag};

   initial clk = 0;
   always #5 clk = ~clk;

   // Reference: returns {co, result} from plain integer arithmetic
   function automatic logic [8:0] model(input int op, input int a, input int b);
      int s = b % 8;
      int r = 0;
      int c = 0;
      case (op)
         0: begin r = a + b; c = int'(r > 255); end
         1: begin r = a - b; c = int'(a >= b); end
         2: r = a & b;
         3: r = a | b;
         4: r = a ^ b;
         5: begin r = a << s; c = (s != 0) ? (a >> (8 - s)) & 1 : 0; end
         6: begin r = a >> s; c = (s != 0) ? (a >> (s - 1)) & 1 : 0; end
         default: r = b;
      endcase
      return {c[0], 8'(r & 255)};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] tag, output int waits);
      in_valid = 1; in_op = op; in_a = a; in_b = b; in_tag = tag; waits = 0;
      @(negedge clk);
      while (!in_ready && waits < 1000) begin waits++; @(negedge clk); end
      if (!in_ready) begin
         checks++; errors++;
         $display("FAIL send timeout: actual in_ready 0 required 1");
      end
      @(posedge clk); #1 in_valid = 0;
   endtask

   task automatic expect_out(input string name, input logic [7:0] res, input logic co,
                             input logic [3:0] tag, output int waits);
      waits = 0;
      @(negedge clk);
      while (!out_valid && waits < 20) begin waits++; @(negedge clk); end
      chk({name, " valid"}, out_valid, 1);
      chk({name, " result"}, out_result, res);
      chk({name, " co"}, out_co, co);
      chk({name, " zero"}, out_zero, res == 0);
      chk({name, " tag"}, out_tag, tag);
      @(posedge clk); #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 30 && (exp_q.size() != 0 || busy); i++) @(negedge clk);
      chk("drain empty", exp_q.size(), 0);
      @(posedge clk); #1;
   endtask

   always @(negedge clk) begin
      if (!rst && in_valid && in_ready) begin
         m = model(int'(in_op), int'(in_a), int'(in_b));
         exp_q.push_back({m[7:0], m[8], m[7:0] == 8'd0, 1'b0, in_tag});
         acc++;
      end
   end

   always @(negedge clk) begin
      if (rst) stalled = 0;
      else begin
         if (stalled) chk("hold stable", bundle, held);
         if (out_valid && out_ready) begin
            pops++;
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected response: actual %0h required none", bundle);
            end else chk("response", bundle, exp_q.pop_front());
         end
         stalled = out_valid && !out_ready;
         held = bundle;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1; in_valid = 0; in_op = 0; in_a = 0; in_b = 0; in_tag = 0; out_ready = 1;
      @(negedge clk);
      chk("reset out_valid", out_valid, 0);
      chk("reset busy", busy, 0);
      chk("reset data", bundle, 0);
      #2 rst = 0;
      #1 chk("reset in_ready", in_ready, 1);
      @(posedge clk); #1;

      send(3'd0, 8'hFF, 8'h01, 4'd3, w);
      @(negedge clk) chk("add early", out_valid, 0);
      expect_out("add", 8'h00, 1'b1, 4'd3, n);
      chk("add latency", n, 0);
      send(3'd1, 8'h05, 8'h07, 4'd1, w); expect_out("sub", 8'hFE, 1'b0, 4'd1, n);
      send(3'd5, 8'h81, 8'd1, 4'd2, w);  expect_out("shl1", 8'h02, 1'b1, 4'd2, n);
      send(3'd6, 8'h81, 8'd0, 4'd4, w);  expect_out("shr0", 8'h81, 1'b0, 4'd4, n);
      send(3'd6, 8'h80, 8'd7, 4'd5, w);  expect_out("shr7", 8'h01, 1'b0, 4'd5, n);
      drain();

      stalls = 0; gaps = 0; pops0 = pops;
      fork
         for (int i = 0; i < 16; i++) begin
            send(3'd4, 8'($urandom), 8'($urandom), 4'(i), w);
            stalls += w;
         end
         begin
            n = 0;
            @(negedge clk);
            while (!out_valid && n < 10) begin n++; @(negedge clk); end
            for (int i = 1; i < 16; i++) begin @(negedge clk); if (!out_valid) gaps++; end
         end
      join
      chk("stream in_ready", stalls, 0);
      chk("stream gaps", gaps, 0);
      drain();
      chk("stream count", pops - pops0, 16);

      out_ready = 0; acc0 = acc; pops0 = pops;
      fork
         for (int i = 0; i < 3; i++) send(3'd2, 8'($urandom), 8'($urandom), 4'(8 + i), w);
         begin
            repeat (6) @(negedge clk);
            #1;
            chk("bp accepted", acc - acc0, 2);
            chk("bp in_ready", in_ready, 0);
            chk("bp out_valid", out_valid, 1);
            hold = bundle;
            repeat (3) @(negedge clk);
            chk("bp hold", bundle, hold);
            @(posedge clk); #1 out_ready = 1;
            #1 chk("bp in_ready rise", in_ready, 1);
         end
      join
      drain();
      chk("bp responses", pops - pops0, 3);

      out_ready = 0;
      send(3'd7, 8'h00, 8'h11, 4'd1, w);
      send(3'd7, 8'h00, 8'h22, 4'd2, w);
      #2 rst = 1;
      exp_q.delete();
      #1;
      chk("rst out_valid", out_valid, 0);
      chk("rst busy", busy, 0);
      chk("rst out_result", out_result, 0);
      #3 rst = 0; out_ready = 1;
      stale = 0;
      repeat (5) begin @(negedge clk); stale += int'(out_valid); end
      chk("rst stale", stale, 0);
      @(posedge clk); #1;
      send(3'd7, 8'h00, 8'h5A, 4'd6, w);
      expect_out("passb", 8'h5A, 1'b0, 4'd6, n);
      drain();

      acc0 = acc;
      for (int i = 0; i < 80000 && acc - acc0 < 10000; i++) begin
         in_valid = ($urandom % 4) != 0;
         in_op = 3'($urandom); in_a = 8'($urandom); in_b = 8'($urandom); in_tag = 4'($urandom);
         out_ready = ($urandom % 4) != 0;
         @(posedge clk); #1;
      end
      in_valid = 0; out_ready = 1;
      chk("random accepted", acc - acc0, 10000);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
